// File: rtl/relu_stream_ctrl.sv
// Run-length sequencer that pulls bound-domain words from upstream, applies saturating ReLU
// and presents the results through a registered valid/ready stage.
module relu_stream_ctrl #(
    parameter int unsigned BO_BW  = 8,
    parameter int unsigned ACT_BW = 8,
    parameter int unsigned CNT_BW = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [CNT_BW-1:0] i_num_elem,
    output logic              o_idle,
    output logic              o_running,
    output logic              o_done,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [BO_BW-1:0]  i_bound_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ACT_BW-1:0] o_act_data,
    output logic [CNT_BW-1:0] o_neg_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Largest value representable in the activation domain, widened so the compare cannot overflow.
    localparam logic [BO_BW:0] ActMax = (BO_BW + 1)'((64'd1 << ACT_BW) - 64'd1);

    state_e            state_q, state_d;
    logic [CNT_BW-1:0] num_q, num_d;
    logic [CNT_BW-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_BW-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_BW-1:0] neg_cnt_q, neg_cnt_d;
    logic              valid_q, valid_d;
    logic [ACT_BW-1:0] act_q, act_d;
    logic              in_hs, out_hs;

    function automatic logic [ACT_BW-1:0] relu(input logic [BO_BW-1:0] x);
        logic [BO_BW:0] ext;
        ext = {1'b0, x};
        if (x[BO_BW-1]) begin
            relu = '0;
        end else if (ext > ActMax) begin
            relu = '1;
        end else begin
            relu = x[ACT_BW-1:0];
        end
    endfunction

    assign o_ready   = (state_q == StRun) && (in_cnt_q < num_q) && (!valid_q || i_ready);
    assign in_hs     = i_valid && o_ready;
    assign out_hs    = valid_q && i_ready;
    assign o_idle    = (state_q == StIdle);
    assign o_running = (state_q == StRun);
    assign o_done    = (state_q == StDone);
    assign o_valid   = valid_q;
    assign o_act_data = act_q;
    assign o_neg_cnt = neg_cnt_q;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        neg_cnt_d = neg_cnt_q;
        valid_d   = valid_q;
        act_d     = act_q;

        unique case (state_q)
            StIdle: begin
                if (i_run) begin
                    neg_cnt_d = '0;
                    if (i_num_elem != '0) begin
                        state_d   = StRun;
                        num_d     = i_num_elem;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    act_d    = relu(i_bound_data);
                    valid_d  = 1'b1;
                    if (i_bound_data[BO_BW-1]) begin
                        neg_cnt_d = neg_cnt_q + 1'b1;
                    end
                end else if (out_hs) begin
                    valid_d = 1'b0;
                end
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == num_q - 1'b1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            num_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            neg_cnt_q <= '0;
            valid_q   <= 1'b0;
            act_q     <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            neg_cnt_q <= neg_cnt_d;
            valid_q   <= valid_d;
            act_q     <= act_d;
        end
    end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Directed bench for relu_stream_ctrl: an 8-bit-input and a 12-bit-input instance share
// control and handshake stimulus; each step checks outputs with immediate assertions.
module tb_relu_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_run;
    logic [15:0] i_num_elem;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  data8;
    logic [11:0] data12;

    logic        idle8, running8, done8, ready8, valid8;
    logic [7:0]  act8;
    logic [15:0] neg8;
    logic        idle12, running12, done12, ready12, valid12;
    logic [7:0]  act12;
    logic [15:0] neg12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    relu_stream_ctrl #(.BO_BW(8), .ACT_BW(8), .CNT_BW(16)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_run        (i_run),
        .i_num_elem   (i_num_elem),
        .o_idle       (idle8),
        .o_running    (running8),
        .o_done       (done8),
        .i_valid      (i_valid),
        .o_ready      (ready8),
        .i_bound_data (data8),
        .o_valid      (valid8),
        .i_ready      (i_ready),
        .o_act_data   (act8),
        .o_neg_cnt    (neg8)
    );

    relu_stream_ctrl #(.BO_BW(12), .ACT_BW(8), .CNT_BW(16)) dut12 (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_run        (i_run),
        .i_num_elem   (i_num_elem),
        .o_idle       (idle12),
        .o_running    (running12),
        .o_done       (done12),
        .i_valid      (i_valid),
        .o_ready      (ready12),
        .i_bound_data (data12),
        .o_valid      (valid12),
        .i_ready      (i_ready),
        .o_act_data   (act12),
        .o_neg_cnt    (neg12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; checks follow a further settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; i_run = 1'b0; i_num_elem = '0; i_valid = 1'b0; i_ready = 1'b0;
        data8 = '0; data12 = '0;
        #12;
        chk("rst_idle", idle8, 1); chk("rst_running", running8, 0); chk("rst_done", done8, 0);
        chk("rst_valid", valid8, 0); chk("rst_act", act8, 0); chk("rst_ready", ready8, 0);
        chk("rst_neg", neg8, 0);
        reset_n = 1'b1;

        // Reset mid-run
        tick(); i_run = 1; i_num_elem = 4;
        tick(); i_run = 0; i_valid = 1; i_ready = 1; data8 = 8'h05; #1;
        chk("mr_running", running8, 1); chk("mr_ready", ready8, 1);
        tick(); data8 = 8'h90;
        tick(); i_valid = 0; reset_n = 0; #1;
        chk("mr_idle", idle8, 1); chk("mr_valid", valid8, 0); chk("mr_act", act8, 0);
        chk("mr_ready", ready8, 0); chk("mr_neg", neg8, 0); chk("mr_done", done8, 0);
        reset_n = 1;
        tick(); #1; chk("mr_nodone", done8, 0);
        i_run = 1; i_num_elem = 1;
        tick(); i_run = 0; i_valid = 1; data8 = 8'h03; #1; chk("mr1_ready", ready8, 1);
        tick(); i_valid = 0; #1; chk("mr1_valid", valid8, 1); chk("mr1_act", act8, 8'h03);
        tick(); #1; chk("mr1_done", done8, 1);
        tick(); #1; chk("mr1_idle", idle8, 1); chk("mr1_done_low", done8, 0);

        // Basic run: 05 80 7F FF -> 05 00 7F 00
        i_run = 1; i_num_elem = 4;
        tick(); i_run = 0; i_valid = 1; data8 = 8'h05;
        tick(); data8 = 8'h80; #1; chk("b_out0", act8, 8'h05); chk("b_v0", valid8, 1);
        tick(); data8 = 8'h7F; #1; chk("b_out1", act8, 8'h00);
        tick(); data8 = 8'hFF; #1; chk("b_out2", act8, 8'h7F);
        tick(); i_valid = 0; #1; chk("b_out3", act8, 8'h00); chk("b_full", ready8, 0);
        chk("b_notdone", done8, 0);
        tick(); #1; chk("b_done", done8, 1); chk("b_neg", neg8, 2); chk("b_vclr", valid8, 0);
        tick(); #1; chk("b_idle", idle8, 1);

        // Saturation on the 12-bit instance: 0FF 100 7FF 800 -> FF FF FF 00
        data8 = 0; i_run = 1; i_num_elem = 4;
        tick(); i_run = 0; i_valid = 1; data12 = 12'h0FF;
        tick(); data12 = 12'h100; #1; chk("s_out0", act12, 8'hFF);
        tick(); data12 = 12'h7FF; #1; chk("s_out1", act12, 8'hFF);
        tick(); data12 = 12'h800; #1; chk("s_out2", act12, 8'hFF);
        tick(); i_valid = 0; #1; chk("s_out3", act12, 8'h00);
        tick(); #1; chk("s_done", done12, 1); chk("s_neg", neg12, 1);
        tick(); data12 = 0;

        // Backpressure: num=3, i_ready low for 5 cycles after first valid
        i_run = 1; i_num_elem = 3;
        tick(); i_run = 0; i_valid = 1; data8 = 8'h11;
        tick(); i_ready = 0; data8 = 8'h22; #1;
        chk("bp_act0", act8, 8'h11); chk("bp_ready0", ready8, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("bp_hold_act", act8, 8'h11); chk("bp_hold_valid", valid8, 1);
            chk("bp_hold_ready", ready8, 0);
        end
        i_ready = 1; #1; chk("bp_release", ready8, 1);
        tick(); data8 = 8'h33; #1; chk("bp_act1", act8, 8'h22);
        tick(); i_valid = 0; #1; chk("bp_act2", act8, 8'h33); chk("bp_notdone", done8, 0);
        tick(); #1; chk("bp_done", done8, 1); chk("bp_neg", neg8, 0);
        tick();

        // Overrun guard and ignored i_run: num=2 with a stream of five words
        i_run = 1; i_num_elem = 2;
        tick(); i_run = 0; i_valid = 1; data8 = 8'h81;
        tick(); data8 = 8'h02; i_run = 1; i_num_elem = 7; #1; chk("ov_act0", act8, 8'h00);
        tick(); data8 = 8'h03; i_run = 0; #1;
        chk("ov_act1", act8, 8'h02); chk("ov_full", ready8, 0);
        tick(); data8 = 8'h04; #1;
        chk("ov_done", done8, 1); chk("ov_valid", valid8, 0); chk("ov_neg", neg8, 1);
        tick(); data8 = 8'h05; #1;
        chk("ov_idle", idle8, 1); chk("ov_ready", ready8, 0); chk("ov_valid2", valid8, 0);
        chk("ov_hold", act8, 8'h02);
        i_valid = 0;

        // Zero length
        i_run = 1; i_num_elem = 0;
        tick(); i_run = 0; #1;
        chk("z_done", done8, 1); chk("z_ready", ready8, 0); chk("z_neg", neg8, 0);
        chk("z_running", running8, 0);
        tick(); #1; chk("z_idle", idle8, 1); chk("z_done_low", done8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relu_stream_ctrl.md
# relu_stream_ctrl

Streaming sequencer for the bound-to-activation ReLU stage. It accepts a run command with an element count, pulls exactly that many bound-domain words from an upstream valid/ready stream, and applies ReLU with saturation. It presents the results through a registered valid/ready output stage toward the activation buffer, then reports completion. It sits between the bound/requantize unit and the activation writer, and is started by the layer controller.

## Interface
- BO_BW, 8, width of signed input bound data (two's complement); BO_BW >= ACT_BW
- ACT_BW, 8, width of unsigned output activation
- CNT_BW, 16, width of element counters
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_run  in  1  start pulse; sampled only in IDLE
- i_num_elem  in  CNT_BW  number of elements for the run; sampled with i_run
- o_idle  out  1  high in IDLE
- o_running  out  1  high in RUN
- o_done  out  1  one-cycle pulse, high in DONE
- i_valid  in  1  upstream data valid
- o_ready  out  1  ready to accept upstream data
- i_bound_data  in  BO_BW  signed bound-domain element
- o_valid  out  1  output data valid (registered)
- i_ready  in  1  downstream ready
- o_act_data  out  ACT_BW  activation element (registered)
- o_neg_cnt  out  CNT_BW  count of elements clamped to 0 in the current/last run

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on i_run with i_num_elem != 0. Latches num, clears in_cnt, out_cnt and o_neg_cnt.
  - IDLE -> DONE on i_run with i_num_elem == 0. Clears o_neg_cnt; no data moves.
  - RUN -> DONE on the output handshake (o_valid && i_ready) with out_cnt == num-1.
  - DONE -> IDLE unconditionally after one cycle.
- i_run is ignored in RUN and DONE. i_num_elem is ignored except when sampled with i_run.
- o_ready = (state==RUN) && (in_cnt < num) && (!o_valid || i_ready). Upstream words are never accepted beyond num, nor outside RUN.
- Input handshake (i_valid && o_ready):
  - in_cnt increments.
  - o_act_data loads f(i_bound_data) and o_valid sets.
  - If the sign bit i_bound_data[BO_BW-1] is 1, o_neg_cnt increments.
- ReLU function f:
  - Sign bit 1 -> 0.
  - Nonnegative value > 2^ACT_BW-1 -> all ones.
  - Otherwise -> the low ACT_BW bits.
- Output handshake (o_valid && i_ready) with no new input handshake in the same cycle: o_valid clears and out_cnt increments.
- Output handshake and input handshake in the same cycle: o_valid stays 1, data is replaced, and out_cnt increments.
- While o_valid && !i_ready: o_act_data and o_valid hold stable and o_ready is 0.
- o_neg_cnt holds its value after DONE until the next accepted i_run.
- Counters do not wrap: in_cnt <= num and out_cnt <= num by construction. num = 2^CNT_BW-1 is legal.

## Timing
- Reset (async assert, sync-to-clk deassert by the system) values:
  - state = IDLE, so o_idle=1, o_running=0, o_done=0.
  - o_valid=0, o_act_data=0, o_ready=0, o_neg_cnt=0.
  - Internal counters = 0.
- Reset asserted mid-run: all state returns to reset values immediately. Partial data is discarded and no o_done is issued.
- Start latency: i_run sampled at edge N; o_running=1 and o_ready may be 1 in cycle N+1.
- Data latency: one cycle from input handshake to o_valid.
- Throughput: one element per clock while i_valid=1 and i_ready=1.
- o_done is high in exactly the cycle after the final output handshake. o_idle returns one cycle later.
- A zero-length run gives o_done high in the cycle after i_run.
- Outputs o_ready, o_idle, o_running and o_done are decoded from registers only. o_ready additionally depends combinationally on i_ready.

## Test plan
- Reset mid-run: start num=4, accept 2 words, pulse reset_n low -> all outputs at reset values; no o_done; new run of num=1 completes normally.
- Basic run (BO_BW=ACT_BW=8): num=4, inputs 0x05, 0x80, 0x7F, 0xFF with i_ready=1 -> outputs 0x05, 0x00, 0x7F, 0x00 on consecutive cycles; o_neg_cnt=2; o_done one cycle after the 4th output.
- Saturation (BO_BW=12, ACT_BW=8): inputs 0x0FF, 0x100, 0x7FF, 0x800 -> 0xFF, 0xFF, 0xFF, 0x00; o_neg_cnt=1.
- Backpressure: num=3, i_ready held 0 for 5 cycles after the first o_valid -> o_act_data stable, o_ready=0, no extra input accepted; all 3 outputs delivered in order after i_ready returns.
- Overrun guard and ignore: num=2, i_valid held 1 with 5 words available -> exactly 2 accepted and o_ready=0 afterward. i_run pulsed during RUN -> ignored, still exactly 2 outputs.
- Zero length: i_run with i_num_elem=0 -> o_done pulse next cycle, no o_ready, o_neg_cnt=0, back in IDLE after one more cycle.
